instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage of the MIPS pipeline: owns the PC, drives instructionAddress into InstructionMemory
//  (combinational byte-addressed read), captures the returned word into the IF/ID pipeline register.
//  Applies hazard-unit stall, branch/jump redirect with IF/ID flush, and halts when the PC leaves
//  the program region. Downstream consumer is the decode stage.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  PC_LIMIT  32'd512        first byte address outside instruction memory; fetch at >= limit halts
//  NOP_WORD  32'h0000_0000  word loaded into IF/ID on flush/bubble (sll $0,$0,0)
// PORTS
//  clock               in   1   rising-edge clock
//  reset               in   1   synchronous, active-high
//  stall               in   1   hazard unit: hold PC and IF/ID
//  redirect            in   1   branch taken or jump resolved in ID
//  redirectTarget      in   32  new PC when redirect=1
//  instructionAddress  out  32  current PC, to InstructionMemory
//  instructionIn       in   32  word returned by InstructionMemory for instructionAddress
//  ifIdInstruction     out  32  registered instruction to decode
//  ifIdPcPlus4         out  32  registered PC+4 of that instruction
//  ifIdValid           out  1   IF/ID holds a real instruction
//  fetchHalted         out  1   FSM in HALTED
// BEHAVIOUR
//  Reset (sync, all regs): PC=RESET_PC, ifIdInstruction=NOP_WORD, ifIdPcPlus4=0, ifIdValid=0,
//   fetchHalted=0, state=RUN. Reset mid-operation discards everything in flight on that edge.
//  instructionAddress = PC register directly (no extra latency); instructionIn is sampled same cycle.
//  Latency: instruction at PC appears on ifIdInstruction one edge after PC is presented.
//  FSM states RUN, HALTED. Per rising edge, priority reset > redirect > stall > advance:
//   redirect=1 (any state): PC<=redirectTarget; IF/ID<=NOP_WORD, ifIdValid<=0 (flush);
//    state<=RUN if redirectTarget<PC_LIMIT, else HALTED. Redirect beats a simultaneous stall.
//   RUN, stall=1: PC, IF/ID, ifIdValid all hold.
//   RUN, advance: IF/ID<=instructionIn, ifIdPcPlus4<=PC+4, ifIdValid<=1; PC<=PC+4;
//    if PC+4 >= PC_LIMIT: state<=HALTED (last in-range word still delivered valid).
//   HALTED, no redirect: PC holds; IF/ID<=NOP_WORD, ifIdValid<=0 each edge (stall ignored);
//    fetchHalted=1. Only redirect to in-range target or reset leaves HALTED.
//  Arithmetic: PC+4 is 32-bit modulo; comparisons against PC_LIMIT unsigned. PC low 2 bits are
//   not forced; alignment handled by the optional check below.
//  instructionIn never read while HALTED (memory beyond PC_LIMIT is undefined).
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: extra output fetchMisaligned (1 bit, reset 0). A redirect whose
//   redirectTarget[1:0]!=0 is not taken: PC holds, IF/ID flushed, state<=HALTED, fetchMisaligned<=1
//   (sticky until reset). RESET_PC misaligned is a parameter error ($error at elaboration).
//  Not defined: port absent; redirectTarget loaded unchanged, misaligned fetch reads straddling bytes.
// TESTING
//  Reset 2 cycles, memory word@0=32'h2108_0008 -> after first free edge ifIdInstruction=32'h2108_0008,
//   ifIdPcPlus4=4, ifIdValid=1, instructionAddress=4.
//  Free-run 5 edges -> instructionAddress=20, ifIdPcPlus4=20, ifIdValid=1 throughout.
//  Stall high 3 cycles at PC=8 -> PC stays 8, IF/ID unchanged; release -> word@8 captured next edge.
//  redirect=1 target=32'h24 together with stall=1 at PC=12 -> PC=36, ifIdValid=0, IF/ID=NOP_WORD;
//   next edge IF/ID=word@36, ifIdPcPlus4=40.
//  PC_LIMIT=48, free-run from 0 -> word@44 delivered valid, then fetchHalted=1, ifIdValid=0, PC=48
//   held; redirect target=0 -> RUN, fetch resumes at 0. Reset asserted while PC=28 -> PC=0 next edge.
//  With FETCH_ALIGN_CHECK_EN: redirect target=32'h22 -> PC unchanged, fetchMisaligned=1,
//   fetchHalted=1; reset clears both.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, IF/ID pipeline register, redirect/stall handling and RUN/HALTED FSM.
// Optional FETCH_ALIGN_CHECK_EN adds fetchMisaligned and refuses misaligned redirect targets.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd512,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instructionIn,
    output logic [31:0] ifIdInstruction,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid,
    output logic        fetchHalted
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetchMisaligned
`endif
);

    typedef enum logic {RUN, HALTED} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_p1_q, instr_p1_d;
    logic [31:0] pcp4_p1_q, pcp4_p1_d;
    logic        vld_p1_q, vld_p1_d;
    logic [31:0] pc_plus4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        misaligned_q, misaligned_d;

    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_misaligned
        $error("instruction_fetch_unit: RESET_PC must be word aligned");
    end
`endif

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_p1_d = instr_p1_q;
        pcp4_p1_d  = pcp4_p1_q;
        vld_p1_d   = vld_p1_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif
        if (redirect) begin
            // Any redirect flushes IF/ID; the fetched word belongs to the wrong path.
            instr_p1_d = NOP_WORD;
            vld_p1_d   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirectTarget[1:0] != 2'b00) begin
                state_d      = HALTED;
                misaligned_d = 1'b1;
            end else begin
                pc_d    = redirectTarget;
                state_d = (redirectTarget < PC_LIMIT) ? RUN : HALTED;
            end
`else
            pc_d    = redirectTarget;
            state_d = (redirectTarget < PC_LIMIT) ? RUN : HALTED;
`endif
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!stall) begin
                        instr_p1_d = instructionIn;
                        pcp4_p1_d  = pc_plus4;
                        vld_p1_d   = 1'b1;
                        pc_d       = pc_plus4;
                        // The last in-range word is still delivered before halting.
                        if (pc_plus4 >= PC_LIMIT) begin
                            state_d = HALTED;
                        end
                    end
                end
                HALTED: begin
                    instr_p1_d = NOP_WORD;
                    vld_p1_d   = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Stage boundary: PC (p0) -> IF/ID register (p1)
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            instr_p1_q <= NOP_WORD;
            pcp4_p1_q  <= 32'd0;
            vld_p1_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_p1_q <= instr_p1_d;
            pcp4_p1_q  <= pcp4_p1_d;
            vld_p1_q   <= vld_p1_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    assign instructionAddress = pc_q;
    assign ifIdInstruction    = instr_p1_q;
    assign ifIdPcPlus4        = pcp4_p1_q;
    assign ifIdValid          = vld_p1_q;
    assign fetchHalted        = (state_q == HALTED);
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetchMisaligned    = misaligned_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with PC_LIMIT=48 and a combinational word-per-address memory.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] instructionAddress;
    logic [31:0] instructionIn;
    logic [31:0] ifIdInstruction;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic        fetchHalted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetchMisaligned;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    // Memory: word@0 is 32'h2108_0008, every other address returns C0DE_<addr[15:0]>.
    assign instructionIn = (instructionAddress == 32'd0) ? 32'h2108_0008
                                                         : {16'hC0DE, instructionAddress[15:0]};

    instruction_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_LIMIT(32'd48),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirectTarget(redirectTarget),
        .instructionAddress(instructionAddress),
        .instructionIn(instructionIn),
        .ifIdInstruction(ifIdInstruction),
        .ifIdPcPlus4(ifIdPcPlus4),
        .ifIdValid(ifIdValid),
        .fetchHalted(fetchHalted)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetchMisaligned(fetchMisaligned)
`endif
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectTarget = 32'd0;
        #1;
        step();
        step();
        chk32("rst_addr", instructionAddress, 32'd0);
        chk32("rst_instr", ifIdInstruction, 32'd0);
        chk32("rst_pcp4", ifIdPcPlus4, 32'd0);
        chk1("rst_valid", ifIdValid, 1'b0);
        chk1("rst_halted", fetchHalted, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk1("rst_misaligned", fetchMisaligned, 1'b0);
`endif

        reset = 1'b0;
        step();
        chk32("first_instr", ifIdInstruction, 32'h2108_0008);
        chk32("first_pcp4", ifIdPcPlus4, 32'd4);
        chk1("first_valid", ifIdValid, 1'b1);
        chk32("first_addr", instructionAddress, 32'd4);

        step();
        chk32("pc8_addr", instructionAddress, 32'd8);
        chk32("pc8_instr", ifIdInstruction, 32'hC0DE_0004);

        // Stall three cycles at PC=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk32("stall_addr", instructionAddress, 32'd8);
            chk32("stall_instr", ifIdInstruction, 32'hC0DE_0004);
            chk32("stall_pcp4", ifIdPcPlus4, 32'd8);
            chk1("stall_valid", ifIdValid, 1'b1);
        end
        stall = 1'b0;
        step();
        chk32("release_instr", ifIdInstruction, 32'hC0DE_0008);
        chk32("release_pcp4", ifIdPcPlus4, 32'd12);
        chk32("release_addr", instructionAddress, 32'd12);

        // Redirect with simultaneous stall at PC=12
        redirect = 1'b1; redirectTarget = 32'h24; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk32("redir_addr", instructionAddress, 32'd36);
        chk1("redir_valid", ifIdValid, 1'b0);
        chk32("redir_instr", ifIdInstruction, 32'd0);
        step();
        chk32("after_redir_instr", ifIdInstruction, 32'hC0DE_0024);
        chk32("after_redir_pcp4", ifIdPcPlus4, 32'd40);
        step();
        chk32("pc44_addr", instructionAddress, 32'd44);
        chk1("pc44_halted", fetchHalted, 1'b0);

        // Last in-range word delivered, then halt
        step();
        chk32("last_instr", ifIdInstruction, 32'hC0DE_002C);
        chk32("last_pcp4", ifIdPcPlus4, 32'd48);
        chk1("last_valid", ifIdValid, 1'b1);
        chk1("last_halted", fetchHalted, 1'b1);
        chk32("last_addr", instructionAddress, 32'd48);
        step();
        chk1("halt_valid", ifIdValid, 1'b0);
        chk32("halt_instr", ifIdInstruction, 32'd0);
        chk32("halt_addr", instructionAddress, 32'd48);
        chk1("halt_halted", fetchHalted, 1'b1);
        stall = 1'b1;
        step();
        stall = 1'b0;
        chk32("halt_stall_addr", instructionAddress, 32'd48);
        chk1("halt_stall_valid", ifIdValid, 1'b0);

        // Redirect to 0 resumes
        redirect = 1'b1; redirectTarget = 32'd0;
        step();
        redirect = 1'b0;
        chk1("resume_halted", fetchHalted, 1'b0);
        chk32("resume_addr", instructionAddress, 32'd0);
        chk1("resume_valid", ifIdValid, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk32("run_addr", instructionAddress, 32'(4 * i));
            chk32("run_pcp4", ifIdPcPlus4, 32'(4 * i));
            chk1("run_valid", ifIdValid, 1'b1);
        end
        chk32("run5_instr", ifIdInstruction, 32'hC0DE_0010);
        step();
        step();
        chk32("pc28_addr", instructionAddress, 32'd28);

        // Reset mid-operation
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk32("midrst_addr", instructionAddress, 32'd0);
        chk1("midrst_valid", ifIdValid, 1'b0);
        chk32("midrst_instr", ifIdInstruction, 32'd0);
        chk32("midrst_pcp4", ifIdPcPlus4, 32'd0);
        step();
        chk32("postrst_instr", ifIdInstruction, 32'h2108_0008);

        // Redirect to an out-of-range target halts immediately
        redirect = 1'b1; redirectTarget = 32'h100;
        step();
        redirect = 1'b0;
        chk32("oor_addr", instructionAddress, 32'h100);
        chk1("oor_halted", fetchHalted, 1'b1);
        chk1("oor_valid", ifIdValid, 1'b0);
        redirect = 1'b1; redirectTarget = 32'h8;
        step();
        redirect = 1'b0;
        chk1("back_halted", fetchHalted, 1'b0);
        chk32("back_addr", instructionAddress, 32'd8);

        // Misaligned redirect target
        redirect = 1'b1; redirectTarget = 32'h22;
        step();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk32("mis_addr", instructionAddress, 32'd8);
        chk1("mis_flag", fetchMisaligned, 1'b1);
        chk1("mis_halted", fetchHalted, 1'b1);
        chk1("mis_valid", ifIdValid, 1'b0);
        step();
        chk1("mis_sticky", fetchMisaligned, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk1("mis_rst_flag", fetchMisaligned, 1'b0);
        chk1("mis_rst_halted", fetchHalted, 1'b0);
`else
        chk32("mis_addr", instructionAddress, 32'h22);
        chk1("mis_halted", fetchHalted, 1'b0);
        step();
        chk32("mis_instr", ifIdInstruction, 32'hC0DE_0022);
        chk32("mis_pcp4", ifIdPcPlus4, 32'h26);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
